// File: rtl/ip_dec_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the IP decoder arbiter slice.
package ip_dec_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE      = 3'd1,
    STREAM   = 3'd2,
    WAIT_FIN = 3'd3,
    DONE     = 3'd4
  } arb_state_e;

  localparam logic [7:0] PROTO_TCP = 8'd6;
  localparam logic [7:0] PROTO_UDP = 8'd17;
  localparam int FIN_TIMEOUT_DEF = 64;

  function automatic logic proto_known(input logic [7:0] p);
    return (p == PROTO_TCP) || (p == PROTO_UDP);
  endfunction

endpackage

// File: rtl/ip_dec_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of RX source, decoder and status signals around the arbiter.
interface ip_dec_arbiter_if #(
  parameter int N_SRC = 2,
  parameter int SRC_W = 1
);
  logic [32*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]    src_valid;
  logic [N_SRC-1:0]    src_last;
  logic [N_SRC-1:0]    src_ready;
  logic [31:0]         dec_data;
  logic                dec_start;
  logic                dec_reset;
  logic                dec_fin;
  logic                dec_ok;
  logic [7:0]          dec_protocol;
  logic [N_SRC-1:0]    grant;
  logic                busy;
  logic                pkt_done;
  logic                pkt_ok;
  logic [SRC_W-1:0]    pkt_src;
  logic [7:0]          pkt_proto;
  logic                timeout_err;
  logic                abort_err;

  // Arbiter side
  modport master (
    input  src_data, src_valid, src_last, dec_fin, dec_ok, dec_protocol,
    output src_ready, dec_data, dec_start, dec_reset, grant, busy,
           pkt_done, pkt_ok, pkt_src, pkt_proto, timeout_err, abort_err
  );

  // Sources, decoder and status consumer side
  modport slave (
    output src_data, src_valid, src_last, dec_fin, dec_ok, dec_protocol,
    input  src_ready, dec_data, dec_start, dec_reset, grant, busy,
           pkt_done, pkt_ok, pkt_src, pkt_proto, timeout_err, abort_err
  );
endinterface

// File: rtl/ip_dec_arbiter_rr_pick.sv
`timescale 1ns/1ps
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
module ip_dec_arbiter_rr_pick
  import ip_dec_arbiter_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int SRC_W = 1
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic [N_SRC-1:0] gnt_o,
  output logic [SRC_W-1:0] idx_o
);

  logic             found;
  logic [SRC_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = SRC_W'((int'(ptr_i) + i) % N_SRC);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_dec_arbiter.sv
`timescale 1ns/1ps
// Shares one IP_decoder between N_SRC RX word streams, round-robin per packet.
// Define IP_ARB_PROTO_FILTER_EN to report only TCP/UDP packets as ok.
//
// state    | meaning
// IDLE     | waiting for any src_valid, decoder released
// PRE      | one-cycle decoder reset before the packet
// STREAM   | forwarding granted source words to the decoder
// WAIT_FIN | waiting for dec_fin, bounded by FIN_TIMEOUT
// DONE     | one-cycle pkt_done with status, advance rr pointer
module ip_dec_arbiter
  import ip_dec_arbiter_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int SRC_W       = 1,
  parameter int FIN_TIMEOUT = FIN_TIMEOUT_DEF,
  parameter int TO_W        = 7
) (
  input logic               clk,
  input logic               reset,
  ip_dec_arbiter_if.master  bus
);

  arb_state_e       state_q;
  logic [SRC_W-1:0] rr_q, rr_d, gidx_q, pick_idx, pkt_src_q;
  logic [N_SRC-1:0] grant_q, pick_gnt;
  logic [31:0]      dec_data_q, g_data;
  logic [7:0]       pkt_proto_q;
  logic [TO_W-1:0]  cnt_q;
  logic             dec_start_q, dec_reset_q;
  logic             pkt_done_q, pkt_ok_q, timeout_q, abort_q;
  logic             fin_seen_q, ok_seen_q;
  logic             g_valid, g_last, fin_ok_raw, fin_ok;

  ip_dec_arbiter_rr_pick #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_rr_pick (
    .req_i (bus.src_valid),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gidx_q == SRC_W'(i)) begin
        g_data  = bus.src_data[32*i +: 32];
        g_valid = bus.src_valid[i];
        g_last  = bus.src_last[i];
      end
    end
  end

  // A fin seen while still streaming is honoured with the ok captured alongside it.
  always_comb begin
    fin_ok_raw = bus.dec_fin ? bus.dec_ok : ok_seen_q;
`ifdef IP_ARB_PROTO_FILTER_EN
    fin_ok = fin_ok_raw && proto_known(bus.dec_protocol);
`else
    fin_ok = fin_ok_raw;
`endif
  end

  always_comb begin
    rr_d = (gidx_q == SRC_W'(N_SRC - 1)) ? '0 : gidx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      gidx_q      <= '0;
      dec_data_q  <= '0;
      dec_start_q <= 1'b0;
      dec_reset_q <= 1'b1;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      timeout_q   <= 1'b0;
      abort_q     <= 1'b0;
      pkt_src_q   <= '0;
      pkt_proto_q <= '0;
      cnt_q       <= '0;
      fin_seen_q  <= 1'b0;
      ok_seen_q   <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          dec_reset_q <= 1'b0;
          fin_seen_q  <= 1'b0;
          ok_seen_q   <= 1'b0;
          if (|bus.src_valid) begin
            grant_q     <= pick_gnt;
            gidx_q      <= pick_idx;
            dec_reset_q <= 1'b1;
            state_q     <= PRE;
          end
        end
        PRE: begin
          dec_reset_q <= 1'b0;
          state_q     <= STREAM;
        end
        STREAM: begin
          if (bus.dec_fin) begin
            fin_seen_q <= 1'b1;
            ok_seen_q  <= bus.dec_ok;
          end
          if (g_valid) begin
            dec_data_q  <= g_data;
            dec_start_q <= 1'b1;
            if (g_last) begin
              cnt_q   <= TO_W'(FIN_TIMEOUT - 1);
              state_q <= WAIT_FIN;
            end
          end else begin
            // Gap inside a packet: abandon it and flush the decoder.
            dec_start_q <= 1'b0;
            dec_reset_q <= 1'b1;
            pkt_done_q  <= 1'b1;
            pkt_ok_q    <= 1'b0;
            timeout_q   <= 1'b0;
            abort_q     <= 1'b1;
            pkt_src_q   <= gidx_q;
            pkt_proto_q <= bus.dec_protocol;
            state_q     <= DONE;
          end
        end
        WAIT_FIN: begin
          dec_start_q <= 1'b0;
          if (bus.dec_fin || fin_seen_q) begin
            pkt_done_q  <= 1'b1;
            pkt_ok_q    <= fin_ok;
            timeout_q   <= 1'b0;
            abort_q     <= 1'b0;
            pkt_src_q   <= gidx_q;
            pkt_proto_q <= bus.dec_protocol;
            state_q     <= DONE;
          end else if (cnt_q == '0) begin
            pkt_done_q  <= 1'b1;
            pkt_ok_q    <= 1'b0;
            timeout_q   <= 1'b1;
            abort_q     <= 1'b0;
            pkt_src_q   <= gidx_q;
            pkt_proto_q <= bus.dec_protocol;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          dec_reset_q <= 1'b0;
          grant_q     <= '0;
          rr_q        <= rr_d;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.src_ready   = (state_q == STREAM) ? grant_q : '0;
  assign bus.dec_data    = dec_data_q;
  assign bus.dec_start   = dec_start_q;
  assign bus.dec_reset   = dec_reset_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.pkt_done    = pkt_done_q;
  assign bus.pkt_ok      = pkt_ok_q;
  assign bus.pkt_src     = pkt_src_q;
  assign bus.pkt_proto   = pkt_proto_q;
  assign bus.timeout_err = timeout_q;
  assign bus.abort_err   = abort_q;

endmodule
